// File: rtl/serial_msg_rx_if.sv
// Interface for serial_msg_rx: transmitter-side inputs plus the message and status outputs
// that go to the alarm control logic.
interface serial_msg_rx_if #(
    parameter int MSG_W = 4
);
    logic             EN;
    logic             serial_send;
    logic             serial_in;
    logic [MSG_W-1:0] msg;
    logic             msg_valid;
    logic             frame_ok;
    logic             busy;
    logic             link_lost;

    modport master (
        output EN, serial_send, serial_in,
        input  msg, msg_valid, frame_ok, busy, link_lost
    );

    modport slave (
        input  EN, serial_send, serial_in,
        output msg, msg_valid, frame_ok, busy, link_lost
    );
endinterface

// File: rtl/serial_msg_rx.sv
// Serial status-link receiver: reassembles LSB-first frames, debounces over CONFIRM identical
// frames and publishes a stable message. Optional link watchdog under SERIAL_RX_TIMEOUT_EN.
module serial_msg_rx #(
    parameter int MSG_W   = 4,
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    serial_msg_rx_if.slave    bus
);
    localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(MSG_W - 1);
    localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [MSG_W-1:0] shift_q,     shift_d;
    logic [MSG_W-1:0] cand_q,      cand_d;
    logic [MSG_W-1:0] msg_q,       msg_d;
    logic [3:0]       match_q,     match_d;
    logic             msg_valid_q, msg_valid_d;
    logic             frame_ok_q,  frame_ok_d;
    logic             busy_q,      busy_d;
    logic             wd_expire;

`ifdef SERIAL_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            lost_q, lost_d;

    // Watchdog restarts on every completed frame; expiry is a single-cycle event.
    always_comb begin
        wd_d      = wd_q;
        lost_d    = lost_q;
        wd_expire = 1'b0;
        if (!bus.EN) begin
            wd_d   = '0;
            lost_d = 1'b0;
        end else if (state_q == ST_CHECK) begin
            wd_d   = '0;
            lost_d = 1'b0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
            if (wd_d == WD_MAX) begin
                lost_d    = 1'b1;
                wd_expire = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            lost_q <= lost_d;
        end
    end

    assign bus.link_lost = lost_q;
`else
    assign wd_expire     = 1'b0;
    assign bus.link_lost = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cand_d      = cand_q;
        msg_d       = msg_q;
        match_d     = match_q;
        msg_valid_d = 1'b0;
        frame_ok_d  = 1'b0;
        busy_d      = busy_q;

        if (!bus.EN) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            cand_d    = '0;
            match_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.serial_send) begin
                        shift_d    = '0;
                        shift_d[0] = bus.serial_in;
                        bit_cnt_d  = CNT_W'(1);
                        busy_d     = 1'b1;
                        state_d    = (MSG_W == 1) ? ST_CHECK : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_d[bit_cnt_q] = bus.serial_in;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    frame_ok_d = 1'b1;
                    busy_d     = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = ST_IDLE;
                    if (shift_q == cand_q) begin
                        match_d = (match_q >= CONFIRM_C) ? CONFIRM_C : match_q + 4'd1;
                    end else begin
                        cand_d  = shift_q;
                        match_d = 4'd1;
                    end
                    // Publish only a newly confirmed value, so a steady link stays quiet.
                    if (match_d == CONFIRM_C && cand_d != msg_q) begin
                        msg_d       = cand_d;
                        msg_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
            if (wd_expire) begin
                cand_d  = '0;
                match_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cand_q      <= '0;
            msg_q       <= '0;
            match_q     <= '0;
            msg_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cand_q      <= cand_d;
            msg_q       <= msg_d;
            match_q     <= match_d;
            msg_valid_q <= msg_valid_d;
            frame_ok_q  <= frame_ok_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.msg       = msg_q;
    assign bus.msg_valid = msg_valid_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_msg_rx.sv
// Self-checking bench for serial_msg_rx: random frames against a frame-history debounce model.
module tb_serial_msg_rx;
    localparam int MSG_W   = 4;
    localparam int CONFIRM = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: every completed frame since the last clear, plus the published message.
    logic [MSG_W-1:0] hist[$];
    logic [MSG_W-1:0] exp_msg;
    logic             exp_valid;

    serial_msg_rx_if #(.MSG_W(MSG_W)) bus ();

    serial_msg_rx #(.MSG_W(MSG_W), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A value is published once the last CONFIRM frames all equal it and it differs from msg.
    task automatic model_frame(input logic [MSG_W-1:0] v);
        bit all_eq;
        hist.push_back(v);
        exp_valid = 1'b0;
        if (hist.size() >= CONFIRM) begin
            all_eq = 1'b1;
            for (int k = hist.size() - CONFIRM; k < hist.size(); k++)
                if (hist[k] != v) all_eq = 1'b0;
            if (all_eq && v != exp_msg) begin
                exp_msg   = v;
                exp_valid = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.EN          = 1'($urandom);
        bus.serial_send = 1'($urandom);
        bus.serial_in   = 1'($urandom);
        tick();
        tick();
        tick();
        rst_n           = 1'b1;
        bus.EN          = 1'b1;
        bus.serial_send = 1'b0;
        hist.delete();
        exp_msg   = '0;
        exp_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [MSG_W-1:0] v, input int gap);
        bus.serial_send = 1'b1;
        bus.serial_in   = v[0];
        tick();
        bus.serial_send = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.frame_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_start busy=%b frame_ok=%b, required busy=1 frame_ok=0", bus.busy, bus.frame_ok);
        end
        for (int i = 1; i < MSG_W; i++) begin
            bus.serial_in = v[i];
            tick();
            n_checks++;
            if (bus.busy !== 1'b1 || bus.frame_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_shift bit %0d busy=%b frame_ok=%b, required busy=1 frame_ok=0", i, bus.busy, bus.frame_ok);
            end
        end
        bus.serial_in = 1'($urandom);
        tick();
        model_frame(v);
        n_checks++;
        if (bus.frame_ok !== 1'b1 || bus.busy !== 1'b0 || bus.msg !== exp_msg ||
            bus.msg_valid !== exp_valid || bus.link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_check frame=%h: frame_ok=%b busy=%b msg=%h msg_valid=%b link_lost=%b, required 1 0 %h %b 0",
                     v, bus.frame_ok, bus.busy, bus.msg, bus.msg_valid, bus.link_lost, exp_msg, exp_valid);
        end
        $display("frame %h: msg=%h msg_valid=%b (expected msg=%h msg_valid=%b)", v, bus.msg, bus.msg_valid, exp_msg, exp_valid);
        for (int g = 0; g < gap; g++) begin
            bus.serial_in = 1'($urandom);
            tick();
            n_checks++;
            if (bus.frame_ok !== 1'b0 || bus.msg_valid !== 1'b0 || bus.busy !== 1'b0 || bus.msg !== exp_msg) begin
                n_fail++;
                $display("FAIL frame_gap frame_ok=%b msg_valid=%b busy=%b msg=%h, required 0 0 0 %h",
                         bus.frame_ok, bus.msg_valid, bus.busy, bus.msg, exp_msg);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.msg !== '0 || bus.msg_valid !== 1'b0 || bus.frame_ok !== 1'b0 ||
            bus.busy !== 1'b0 || bus.link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset msg=%h msg_valid=%b frame_ok=%b busy=%b link_lost=%b, required all 0",
                     bus.msg, bus.msg_valid, bus.frame_ok, bus.busy, bus.link_lost);
        end
        $display("reset: outputs msg=%h busy=%b", bus.msg, bus.busy);
    endtask

    task automatic test_single_frame();
        do_reset();
        drive_frame(4'hA, 2);
    endtask

    task automatic test_confirm();
        do_reset();
        drive_frame(4'hA, 2);
        drive_frame(4'hA, 2);
        drive_frame(4'hA, 2);
    endtask

    task automatic test_alternating();
        do_reset();
        drive_frame(4'hA, 1);
        drive_frame(4'h5, 1);
        drive_frame(4'hA, 1);
        drive_frame(4'hA, 1);
    endtask

    task automatic test_send_held();
        logic [MSG_W-1:0] v;
        logic exp_fok, exp_busy;
        do_reset();
        v = MSG_W'($urandom_range(1, 15));
        for (int c = 0; c < 10; c++) begin
            bus.serial_send = (c < 6);
            bus.serial_in   = (c < 4) ? v[c] : (c >= 5 && c < 9) ? v[c-5] : 1'($urandom);
            tick();
            exp_fok  = (c == 4 || c == 9);
            exp_busy = (c != 4 && c != 9);
            if (exp_fok) model_frame(v);
            n_checks++;
            if (bus.frame_ok !== exp_fok || bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL send_held cycle %0d frame_ok=%b busy=%b, required %b %b", c, bus.frame_ok, bus.busy, exp_fok, exp_busy);
            end
        end
        n_checks++;
        if (bus.msg !== exp_msg || bus.msg_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL send_held_msg msg=%h valid=%b, required %h %b", bus.msg, bus.msg_valid, exp_msg, exp_valid);
        end
        $display("send_held: two frames %h, msg=%h", v, bus.msg);
        bus.serial_send = 1'b0;
        tick();
    endtask

    task automatic test_en_drop();
        logic [MSG_W-1:0] b;
        do_reset();
        drive_frame(4'hA, 1);
        drive_frame(4'hA, 1);
        b = 4'h3;
        drive_frame(b, 1);
        bus.serial_send = 1'b1;
        bus.serial_in   = b[0];
        tick();
        bus.serial_send = 1'b0;
        bus.serial_in   = b[1];
        tick();
        bus.EN = 1'b0;
        tick();
        hist.delete();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.msg !== exp_msg) begin
            n_fail++;
            $display("FAIL en_drop busy=%b frame_ok=%b msg=%h, required 0 0 %h", bus.busy, bus.frame_ok, bus.msg, exp_msg);
        end
        bus.EN = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();
            n_checks++;
            if (bus.frame_ok !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL en_drop_after frame_ok=%b busy=%b, required 0 0", bus.frame_ok, bus.busy);
            end
        end
        $display("en_drop: partial frame discarded, msg=%h", bus.msg);
        drive_frame(b, 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_frame(4'hA, 1);
        drive_frame(4'hA, 1);
        bus.serial_send = 1'b1;
        bus.serial_in   = 1'b1;
        tick();
        bus.serial_send = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.msg !== '0 || bus.msg_valid !== 1'b0 || bus.frame_ok !== 1'b0 ||
            bus.busy !== 1'b0 || bus.link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid msg=%h msg_valid=%b frame_ok=%b busy=%b link_lost=%b, required all 0",
                     bus.msg, bus.msg_valid, bus.frame_ok, bus.busy, bus.link_lost);
        end
        $display("reset_mid: msg=%h busy=%b", bus.msg, bus.busy);
        rst_n = 1'b1;
        hist.delete();
        exp_msg = '0;
        drive_frame(4'h6, 1);
        drive_frame(4'h6, 1);
    endtask

    task automatic test_random();
        logic [MSG_W-1:0] pool[2];
        do_reset();
        pool[0] = MSG_W'($urandom);
        pool[1] = MSG_W'($urandom);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                pool[0] = MSG_W'($urandom);
                pool[1] = MSG_W'($urandom);
            end
            drive_frame(pool[$urandom_range(0, 1)], $urandom_range(1, 3));
        end
    endtask

    task automatic test_link_lost();
        do_reset();
`ifdef SERIAL_RX_TIMEOUT_EN
        drive_frame(4'hC, 0);
        for (int c = 1; c < TIMEOUT; c++) tick();
        n_checks++;
        if (bus.link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL link_lost_early link_lost=%b, required 0", bus.link_lost);
        end
        tick();
        hist.delete();
        n_checks++;
        if (bus.link_lost !== 1'b1 || bus.msg !== exp_msg) begin
            n_fail++;
            $display("FAIL link_lost_set link_lost=%b msg=%h, required 1 %h", bus.link_lost, bus.msg, exp_msg);
        end
        $display("link_lost: asserted after %0d idle cycles", TIMEOUT);
        drive_frame(4'hC, 1);
`else
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            tick();
            n_checks++;
            if (bus.link_lost !== 1'b0) begin
                n_fail++;
                $display("FAIL link_lost_tied cycle %0d link_lost=%b, required 0", c, bus.link_lost);
            end
        end
        $display("link_lost: stayed 0 for %0d idle cycles", TIMEOUT + 8);
`endif
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.EN          = 1'b0;
        bus.serial_send = 1'b0;
        bus.serial_in   = 1'b0;
        exp_msg         = '0;
        exp_valid       = 1'b0;
        test_reset();
        test_single_frame();
        test_confirm();
        test_alternating();
        test_send_held();
        test_en_drop();
        test_reset_mid();
        test_random();
        test_link_lost();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
